// File: rtl/ram_pkg.sv
// Shared definitions for the data-memory responder: size encodings,
// FSM state type and the word-index width helper.
package ram_pkg;

   // RV32I func3 access-size encodings
   localparam logic [2:0] SZ_BYTE = 3'b000;
   localparam logic [2:0] SZ_HALF = 3'b001;
   localparam logic [2:0] SZ_WORD = 3'b010;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   // Number of bits needed to index a word array of the given depth
   function automatic int unsigned idx_width(input int unsigned words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/ram_lane_decode.sv
// Byte-lane decode for a 32-bit store: turns access size and byte offset
// into a lane mask, lane-replicated write data and an illegal-access flag.
module ram_lane_decode
   import ram_pkg::*;
(
   input  logic [2:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  mask_o,
   output logic [31:0] wdata_o,
   output logic        illegal_o
);

   // Replicating the source byte/half across the word places it in every
   // candidate lane, so the mask alone selects what lands in memory.
   always_comb begin
      mask_o    = 4'b0000;
      wdata_o   = wdata_i;
      illegal_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            mask_o  = 4'b0001 << offset_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            illegal_o = offset_i[0];
            mask_o    = 4'b0011 << offset_i;
            wdata_o   = {2{wdata_i[15:0]}};
         end
         SZ_WORD: begin
            illegal_o = (offset_i != 2'b00);
            mask_o    = 4'b1111;
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
      if (illegal_o) begin
         mask_o = 4'b0000;
      end
   end

endmodule

// File: rtl/data_ram.sv
// Data-memory responder for the load/store bus: byte/half/word stores on the
// clock edge, zero-latency shifted loads onto a shared tri-state bus, and a
// zero-fill sweep of the whole array after every reset.
module data_ram
   import ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RAM_WIDTH  = 31,
   parameter int unsigned MEM_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   input  logic                  ram_we,
   input  logic [RAM_WIDTH-1:0]  ram_address,
   input  logic [2:0]            ram_size,
   output logic                  ram_ready,
   output logic                  ram_err
);

   localparam int unsigned IDX_W = idx_width(MEM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_WORDS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
   logic             err_q, err_d;

   logic [31:0] mem [MEM_WORDS];

   logic [IDX_W-1:0] word_idx;
   logic [1:0]       offset;
   logic             out_of_range;
   logic             size_legal;
   logic             access_ok;

   logic [3:0]  lane_mask;
   logic [31:0] lane_wdata;
   logic        lane_illegal;

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [3:0]       wr_mask;
   logic [31:0]      wr_data;

   logic [31:0] rd_word;
   logic [31:0] rd_data;

   assign word_idx     = ram_address[IDX_W+1:2];
   assign offset       = ram_address[1:0];
   assign out_of_range = |ram_address[RAM_WIDTH-1:IDX_W+2];
   assign size_legal   = (ram_size == SZ_BYTE) || (ram_size == SZ_HALF) ||
                         (ram_size == SZ_WORD);
   assign access_ok    = (state_q == RUN) && !out_of_range && !lane_illegal;

   ram_lane_decode u_lane_decode (
      .size_i    (ram_size),
      .offset_i  (offset),
      .wdata_i   (ram_data),
      .mask_o    (lane_mask),
      .wdata_o   (lane_wdata),
      .illegal_o (lane_illegal)
   );

   // Next state, sweep pointer and error flag
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      err_d      = 1'b0;
      case (state_q)
         INIT: begin
            init_ptr_d = init_ptr_q + IDX_W'(1);
            if (init_ptr_q == LAST_IDX) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (ram_we) begin
               err_d = out_of_range || lane_illegal;
            end else begin
               // Unknown size encodings on a load are not flagged
               err_d = size_legal && (out_of_range || lane_illegal);
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // FSM, sweep pointer and error registers; reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= INIT;
         init_ptr_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
         err_q      <= err_d;
      end
   end

   // Single write port shared by the zero-fill sweep and accepted stores
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = word_idx;
      wr_mask = lane_mask;
      wr_data = lane_wdata;
      if (state_q == INIT) begin
         wr_en   = 1'b1;
         wr_idx  = init_ptr_q;
         wr_mask = 4'b1111;
         wr_data = 32'h0;
      end else if (ram_we && access_ok) begin
         wr_en = 1'b1;
      end
   end

   // Byte-masked array write, suppressed while reset is asserted
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) begin
               mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Combinational read: addressed byte/half lands at bit 0, zero-filled above
   always_comb begin
      rd_word = mem[word_idx];
      rd_data = 32'h0;
      if (access_ok) begin
         rd_data = rd_word >> {offset, 3'b000};
      end
   end

   assign ram_ready = (state_q == RUN);
   assign ram_err   = err_q;
   assign ram_data  = ram_we ? {DATA_WIDTH{1'bz}} : rd_data;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: init sweep and restart, word/byte/half
// round trips, rejected accesses and bus ownership.
module tb_data_ram;

   logic        clk;
   logic        rst;
   logic        tb_we;
   logic [31:0] tb_wdata;
   logic [30:0] addr;
   logic [2:0]  size;
   logic        ready;
   logic        err;
   wire  [31:0] ram_data;

   int n_checks;
   int n_fail;

   assign ram_data = tb_we ? tb_wdata : 'z;

   data_ram #(
      .DATA_WIDTH (32),
      .RAM_WIDTH  (31),
      .MEM_WORDS  (256)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ram_data    (ram_data),
      .ram_we      (tb_we),
      .ram_address (addr),
      .ram_size    (size),
      .ram_ready   (ready),
      .ram_err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a load and let the combinational path settle
   task automatic load(input logic [30:0] a, input logic [2:0] s);
      tb_we = 1'b0;
      addr  = a;
      size  = s;
      #1;
   endtask

   task automatic store(input logic [30:0] a, input logic [2:0] s, input logic [31:0] d);
      tb_we    = 1'b1;
      addr     = a;
      size     = s;
      tb_wdata = d;
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      tb_we    = 1'b0;
      tb_wdata = 32'h0;
      addr     = 31'h0;
      size     = 3'b010;
      tick();
      tick();
      chk("reset_ready", {31'h0, ready}, 32'h0);
      chk("reset_err", {31'h0, err}, 32'h0);

      // First sweep, interrupted after 100 cycles
      rst = 1'b0;
      repeat (100) tick();
      chk("init_ready_100", {31'h0, ready}, 32'h0);
      chk("init_load_zero", ram_data, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Restarted sweep: 256 cycles to ready; a store mid-sweep is ignored
      repeat (10) tick();
      store(31'h0, 3'b010, 32'hFFFF_FFFF);
      chk("init_bus_z", ram_data, 32'hFFFF_FFFF);
      tick();
      chk("init_store_no_err", {31'h0, err}, 32'h0);
      load(31'h0, 3'b010);
      repeat (244) tick();
      chk("init_ready_255", {31'h0, ready}, 32'h0);
      chk("init_no_err", {31'h0, err}, 32'h0);
      tick();
      chk("init_ready_256", {31'h1, ready} & 32'h1, 32'h1);
      load(31'h0, 3'b010);
      chk("swept_word0", ram_data, 32'h0);
      load(31'h3FC, 3'b010);
      chk("swept_word255", ram_data, 32'h0);

      // Word round trip
      store(31'h40, 3'b010, 32'hDEAD_BEEF);
      chk("store_bus_z", ram_data, 32'hDEAD_BEEF);
      tick();
      load(31'h40, 3'b010);
      chk("sw_lw_40", ram_data, 32'hDEAD_BEEF);
      load(31'h41, 3'b000);
      chk("lb_41", ram_data, 32'h00DE_ADBE);
      tick();
      chk("good_no_err", {31'h0, err}, 32'h0);

      // Byte merge
      store(31'h10, 3'b010, 32'h1122_3344);
      tick();
      store(31'h12, 3'b000, 32'h0000_00AA);
      tick();
      load(31'h10, 3'b010);
      chk("merge_lw_10", ram_data, 32'h11AA_3344);
      load(31'h12, 3'b000);
      chk("merge_lb_12", ram_data, 32'h0000_11AA);

      // Half store over zero
      store(31'h22, 3'b001, 32'h1234_BEEF);
      tick();
      load(31'h20, 3'b010);
      chk("sh_lw_20", ram_data, 32'hBEEF_0000);
      load(31'h22, 3'b001);
      chk("sh_lh_22", ram_data, 32'h0000_BEEF);

      // Rejected: misaligned word
      store(31'h42, 3'b010, 32'h1234_5678);
      tick();
      chk("sw42_err", {31'h0, err}, 32'h1);
      load(31'h40, 3'b010);
      chk("sw42_unchanged", ram_data, 32'hDEAD_BEEF);
      tick();
      chk("sw42_err_clear", {31'h0, err}, 32'h0);

      // Rejected: misaligned half
      store(31'h43, 3'b001, 32'h0000_FFFF);
      tick();
      chk("sh43_err", {31'h0, err}, 32'h1);
      load(31'h40, 3'b010);
      chk("sh43_unchanged", ram_data, 32'hDEAD_BEEF);
      tick();
      chk("sh43_err_clear", {31'h0, err}, 32'h0);

      // Rejected: reserved size encoding
      store(31'h40, 3'b011, 32'h0000_0000);
      tick();
      chk("sz011_err", {31'h0, err}, 32'h1);
      load(31'h40, 3'b010);
      chk("sz011_unchanged", ram_data, 32'hDEAD_BEEF);
      tick();
      chk("sz011_err_clear", {31'h0, err}, 32'h0);

      // Rejected: word index 256 must not alias onto word 0
      store(31'h400, 3'b010, 32'hCAFE_F00D);
      tick();
      chk("oor_err", {31'h0, err}, 32'h1);
      load(31'h0, 3'b010);
      chk("oor_no_alias", ram_data, 32'h0);
      tick();
      chk("oor_err_clear", {31'h0, err}, 32'h0);

      // Out-of-range load reads 0 and flags an error
      load(31'h400, 3'b010);
      chk("oor_load_zero", ram_data, 32'h0);
      tick();
      chk("oor_load_err", {31'h0, err}, 32'h1);

      // Back-to-back bad stores hold the error high
      store(31'h42, 3'b010, 32'h0);
      tick();
      chk("b2b_err_1", {31'h0, err}, 32'h1);
      store(31'h43, 3'b001, 32'h0);
      tick();
      chk("b2b_err_2", {31'h0, err}, 32'h1);
      load(31'h40, 3'b010);
      tick();
      chk("b2b_err_clear", {31'h0, err}, 32'h0);
      chk("b2b_unchanged", ram_data, 32'hDEAD_BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
